// File: rtl/doorbell_pkg.sv
// Shared types and constants for the doorbell chime sequencer.
package doorbell_pkg;

  typedef enum logic [1:0] {IDLE, TONE1, TONE2, GAP} chime_state_t;

  localparam logic SRC_FRONT = 1'b0;
  localparam logic SRC_BACK  = 1'b1;

  localparam logic SND_A = 1'b0;
  localparam logic SND_B = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous button level; a level held through
// reset release is not reported as a press.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/doorbell_sequencer.sv
// Two-door chime controller: press capture, one pending slot per door,
// round-robin arbitration and the TONE1/TONE2/GAP chime sequence.
module doorbell_sequencer
  import doorbell_pkg::*;
#(
  parameter int unsigned TONE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W = $clog2((TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_front,
  input  logic btn_back,
  input  logic mute,
  output logic sel,
  output logic play,
  output logic busy,
  output logic src,
  output logic done
);

  localparam int unsigned CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  chime_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_f_q, pend_f_d, pend_b_q, pend_b_d;
  logic          src_q, src_d, last_q, last_d;
  logic          rise_f, rise_b, win, cnt_zero, grant_slot;

  rise_detect u_rise_front (.clk(clk), .rst_n(rst_n), .btn_i(btn_front), .rise_o(rise_f));
  rise_detect u_rise_back  (.clk(clk), .rst_n(rst_n), .btn_i(btn_back),  .rise_o(rise_b));

  assign cnt_zero   = (cnt_q == '0);
  assign grant_slot = (state_q == IDLE) | ((state_q == GAP) & cnt_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_f_q <= 1'b0;
      pend_b_q <= 1'b0;
      src_q    <= SRC_FRONT;
      last_q   <= SRC_BACK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_f_q <= pend_f_d;
      pend_b_q <= pend_b_d;
      src_q    <= src_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
    src_d   = src_q;
    last_d  = last_q;
    // Presses are folded into the pending flags first so an IDLE press is
    // granted on the same edge it is sampled.
    pend_f_d = pend_f_q | (rise_f & ((state_q == IDLE) | (src_q != SRC_FRONT)));
    pend_b_d = pend_b_q | (rise_b & ((state_q == IDLE) | (src_q != SRC_BACK)));
    win      = (pend_f_d & pend_b_d) ? ~last_q : pend_b_d;

    case (state_q)
      TONE1:   if (cnt_zero) begin state_d = TONE2; cnt_d = TONE_LOAD; end
      TONE2:   if (cnt_zero) begin state_d = GAP;   cnt_d = GAP_LOAD;  end
      default: ;
    endcase

    if (grant_slot) begin
      if (pend_f_d | pend_b_d) begin
        state_d = TONE1;
        cnt_d   = TONE_LOAD;
        src_d   = win;
        // The round-robin pointer only moves when both doors actually contend.
        if (pend_f_d & pend_b_d) last_d = win;
        if (win == SRC_BACK) pend_b_d = 1'b0;
        else                 pend_f_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    sel = SND_A;
    case (state_q)
      TONE1:   sel = (src_q == SRC_FRONT) ? SND_A : SND_B;
      TONE2:   sel = (src_q == SRC_FRONT) ? SND_B : SND_A;
      default: sel = SND_A;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == GAP) & cnt_zero;
  assign src  = src_q;
  assign play = ((state_q == TONE1) | (state_q == TONE2)) & ~mute;

endmodule

// File: tb/tb_doorbell_sequencer.sv
// Self-checking bench for doorbell_sequencer: table-driven press scenarios plus
// hand-written corner sequences, checked cycle by cycle against a queue.
module tb_doorbell_sequencer;

  localparam int unsigned T = 8;
  localparam int unsigned G = 4;
  localparam int unsigned L = 2*T + G;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_front = 1'b0;
  logic btn_back = 1'b0;
  logic mute = 1'b0;
  logic sel, play, busy, src, done;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic        f;
    logic        b;
    logic        m;
    int unsigned n;
    logic        first;
  } vec_t;

  vec_t vt[4];

  doorbell_sequencer #(.TONE_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .btn_front(btn_front), .btn_back(btn_back),
    .mute(mute), .sel(sel), .play(play), .busy(busy), .src(src), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {sel, play, busy, src, done} for one complete chime from source s.
  task automatic push_chime(input logic s, input logic muted);
    logic [4:0] w;
    for (int unsigned i = 0; i < L; i++) begin
      if (i < T)          w = {s, 1'b1, 1'b1, s, 1'b0};
      else if (i < 2*T)   w = {~s, ~(muted && (i >= T+2)), 1'b1, s, 1'b0};
      else                w = {1'b0, 1'b0, 1'b1, s, (i == L-1)};
      exp_q.push_back(w);
    end
  endtask

  task automatic push_idle(input int unsigned n, input logic s);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b0, 1'b0, s, 1'b0});
  endtask

  task automatic check(input string name, input int unsigned i);
    logic [4:0] got, want;
    got = {sel, play, busy, src, done};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s[%0d]: no expectation queued, got sel/play/busy/src/done=%b", name, i, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s[%0d]: sel/play/busy/src/done got %b want %b", name, i, got, want);
      end
    end
  endtask

  task automatic step(input logic f, input logic b, input logic m, input logic chk,
                      input string name, input int unsigned i);
    btn_front = f;
    btn_back  = b;
    @(posedge clk);
    #1 mute = m;
    #1;
    if (chk) check(name, i);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    vt[0] = '{f: 1'b1, b: 1'b1, m: 1'b0, n: 2, first: 1'b0};
    vt[1] = '{f: 1'b1, b: 1'b1, m: 1'b0, n: 2, first: 1'b1};
    vt[2] = '{f: 1'b1, b: 1'b0, m: 1'b1, n: 1, first: 1'b0};
    vt[3] = '{f: 1'b0, b: 1'b1, m: 1'b0, n: 1, first: 1'b1};

    #12;
    push_idle(1, 1'b0);
    check("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2, 1'b0);
    for (int unsigned i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "post_reset", i);

    for (int k = 0; k < 4; k++) begin
      cyc = vt[k].n * L + 3;
      push_chime(vt[k].first, vt[k].m);
      if (vt[k].n == 2) push_chime(~vt[k].first, 1'b0);
      push_idle(3, vt[k].first ^ (vt[k].n == 2));
      for (int unsigned i = 0; i < cyc; i++)
        step(vt[k].f && (i == 0), vt[k].b && (i == 0),
             vt[k].m && (i >= T+2) && (i <= 2*T), 1'b1, $sformatf("vec%0d", k), i);
    end

    push_chime(1'b0, 1'b0);
    push_idle(3, 1'b0);
    for (int unsigned i = 0; i < L + 3; i++)
      step((i == 0) || (i == 5), 1'b0, 1'b0, 1'b1, "repress", i);

    push_chime(1'b0, 1'b0);
    push_idle(35, 1'b0);
    for (int unsigned i = 0; i < L + 35; i++)
      step(i < 50, 1'b0, 1'b0, 1'b1, "hold", i);

    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_mid", 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid", 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid", 2);
    rst_n = 1'b0;
    #1;
    push_idle(1, 1'b0);
    check("async_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(25, 1'b0);
    for (int unsigned i = 0; i < 25; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, "after_reset_held", i);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expectations unconsumed, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/doorbell_sequencer.md
# doorbell_sequencer

Chime controller that shares the doorbell sound mux between two requesters, a front-door and a back-door button. It detects button presses, queues at most one pending press per door, and arbitrates round-robin between them. It then drives the mux `sel` line and a `play` enable through a fixed two-tone chime followed by a silent gap. It sits directly upstream of the doorbell mux, where `sel = 0` selects sound a and `sel = 1` selects sound b.

## Interface
- `TONE_CYCLES`, default 8: duration of each tone in clock cycles (≥ 1).
- `GAP_CYCLES`, default 4: silent cycles after the second tone (≥ 1).
- `CNT_W`, default `$clog2(max(TONE_CYCLES, GAP_CYCLES))`: down-counter width.
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_front` in 1: front button level, already synchronous to `clk`.
- `btn_back` in 1: back button level, already synchronous to `clk`.
- `mute` in 1: level; suppresses `play` without altering sequencing.
- `sel` out 1: mux select, 0 = sound a, 1 = sound b.
- `play` out 1: sound enable.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `src` out 1: source being served, 0 = front, 1 = back; holds its last value when idle.
- `done` out 1: one-cycle pulse on the final GAP cycle.

## Operation
- **Press detection.** A press is a rising edge: the current sample is 1 and the previous registered sample is 0. The previous-sample registers reset to 1, so a button held through reset release never produces a press.
- **States:** IDLE, TONE1, TONE2, GAP.
  - IDLE → TONE1 when any press or pending request exists.
  - TONE1 → TONE2 after `TONE_CYCLES` cycles.
  - TONE2 → GAP after `TONE_CYCLES` cycles.
  - GAP → TONE1 if a request is pending, otherwise GAP → IDLE, after `GAP_CYCLES` cycles.
- **Chime patterns.**
  - Front: TONE1 `sel = 0`, TONE2 `sel = 1` (ding-dong).
  - Back: TONE1 `sel = 1`, TONE2 `sel = 0`.
- **Outputs by state.**
  - `sel = 0` in IDLE and GAP.
  - `play = (TONE1 | TONE2) & ~mute`; this is the only combinational output path.
- **Request handling.**
  - A press from the source currently being served, or from a source already pending, is ignored.
  - A press from the other source during TONE1, TONE2 or GAP sets that source's pending flag.
  - The pending flag clears on the edge the request is granted.
- **Arbitration.** This applies when both doors request at grant time (both presses in the same IDLE cycle, or both pending at the end of GAP).
  - The door not served last wins.
  - `last_served` resets to back, so front wins the first contention.
- **Counter.** Loads N−1 on every state entry and decrements to 0; the state advances on the edge where the count is 0. The count never wraps below 0.
- **Reset mid-operation.** Asserting `rst_n` low forces the following immediately, independent of `clk`:
  - state → IDLE;
  - counter, pending flags, `sel`, `play`, `busy`, `done`, `src` → 0;
  - `last_served` → back;
  - previous-sample registers → 1.

## Timing
- **Grant latency.** A press sampled at edge t while in IDLE is granted at edge t (no pending round-trip). TONE1 and `play` are then high from edge t until edge t+`TONE_CYCLES`.
- **Chime length.** One full chime occupies `2*TONE_CYCLES + GAP_CYCLES` cycles with `busy` high. That is 20 cycles at the defaults.
- **`done`.** High during the last GAP cycle.
- **Back-to-back chimes.** A pending request enters TONE1 on the edge that ends GAP, with no IDLE cycle in between. `busy` stays high and `done` still pulses.
- **Mute.** Gating by `mute` takes effect in the same cycle and does not shift any state transition.

## Structure
- Package `doorbell_pkg` holds:
  - the state enum `chime_state_t` {IDLE, TONE1, TONE2, GAP};
  - source constants `SRC_FRONT = 1'b0`, `SRC_BACK = 1'b1`;
  - sound-select constants `SND_A = 1'b0`, `SND_B = 1'b1`.
- Sub-module `rise_detect`: one previous-sample register (async reset to 1) plus the rising-edge output. Instantiated once per button.
- The top level holds the FSM, counter, pending flags and arbiter.

## Test plan
- **Single front press.** Release reset; pulse `btn_front` for 1 cycle at edge t.
  - `play` = 1 from edge t.
  - `sel` = 0 for 8 cycles, then `sel` = 1 for 8 cycles.
  - `play` = 0 for 4 GAP cycles; `done` on cycle t+19.
  - `busy` = 1 for exactly 20 cycles; `src` = 0.
- **Single back press.** Same as above with the tone order reversed: `sel` = 1 for 8 cycles, then `sel` = 0 for 8 cycles; `src` = 1.
- **Simultaneous presses after reset.** Front is served first (cycles 0–19), then back immediately (cycles 20–39), with no idle cycle. Two `done` pulses. Repeating the simultaneous press now serves back first.
- **Ignored re-press and held button.**
  - Re-pressing front during a front chime produces exactly one chime.
  - Holding `btn_front` high for 50 cycles produces one chime.
- **Mute.** Assert `mute` during TONE2. `play` drops in the same cycle while `sel` keeps sequencing; `done` timing is unchanged.
- **Reset mid-chime.** Drop `rst_n` mid-TONE1 with back pending.
  - All outputs go to 0 before the next `clk` edge.
  - After release with `btn_back` still held, no chime occurs.
